fifo_repl_ctrl: RTL and testbench
=================================

# fifo_repl_ctrl

- Replacement controller for one 8-way cache set under FIFO replacement.
- Drives the per-way 3-bit FIFO counters: on a miss request it snapshots all eight counter values (plus way valid bits), selects a victim way, and issues a one-cycle `load` pulse to the victim's counter and `dec` pulses to every counter ordered after it.
- Sits between the cache miss handler (request/acknowledge) and the per-way counter storage (`load`/`dec` strobes).

## Interface

Parameters:
- None. Way count is fixed at 8; counter width is fixed at 3.

Ports:
- `clk` — in — 1 — clock; all state updates on posedge.
- `reset` — in — 1 — synchronous, active-high.
- `req` — in — 1 — replacement request; sampled only in IDLE.
- `ctr_in` — in — 24 — counter values; way w occupies bits [3w+2:3w].
- `valid_in` — in — 8 — way valid bits.
- `busy` — out — 1 — high in every state except IDLE.
- `ack` — out — 1 — one-cycle pulse; `victim` is final.
- `victim` — out — 3 — selected way index.
- `load` — out — 8 — one-hot load strobe to the counters.
- `dec` — out — 8 — decrement strobes to the counters.

## Operation

- **States:** IDLE, SCAN, UPDATE, DONE.
- **IDLE:**
  - When `req`=1, latch `ctr_in` and `valid_in` into snapshot registers.
  - Clear the scan index to 0 and initialise the best candidate to way 0.
  - Go to SCAN.
- **SCAN:**
  - Examine one way per cycle, index 0..7.
  - Track the minimum counter value. On a tie, keep the lower index (strict less-than replaces the best candidate).
  - After index 7, go to UPDATE.
- **UPDATE:** lasts one cycle, then go to DONE.
  - Assert `load[victim]`.
  - Assert `dec[w]` for every way w≠victim whose snapshot counter > snapshot counter of the victim.
  - Never assert `dec` and `load` on the same way.
- **DONE:**
  - Assert `ack`=1 for one cycle, then go to IDLE.
  - `req` still high in IDLE starts a new operation on the next cycle.
- **Hold behaviour:**
  - `victim` holds its value from DONE until the next request is accepted.
  - `load`/`dec` are zero outside UPDATE.
- **Live inputs ignored:** `req`, `ctr_in` and `valid_in` are ignored outside IDLE. Selection uses only the snapshot.
- **Counter arithmetic:**
  - Compare counters as 3-bit unsigned values.
  - `dec` is never asserted on a counter equal to 0, so no wrap is requested.
- **Normal case:** the victim counter is 0, so all other ways decrement.
- **Corrupt case:** no counter equals 0. The minimum is still chosen, and only ways strictly greater than it decrement.

## Timing

- **Reset values** (`reset` high at a posedge):
  - State = IDLE.
  - `busy`=0, `ack`=0, `victim`=0, `load`=0, `dec`=0.
  - Snapshot registers cleared.
- **Reset mid-operation:** abort with no `load`/`dec` pulse. `reset` takes priority over `req`.
- **Full-scan latency:**
  - `req` sampled at edge T.
  - SCAN occupies T+1..T+8.
  - UPDATE occupies T+9.
  - `ack` is high during T+10.
  - `busy` is high T+1..T+10.
- **Strobe timing:**
  - `load`/`dec` are registered outputs held for the whole UPDATE cycle.
  - This lets the counter storage capture them on its negedge within that cycle.
- **Back-to-back requests:** minimum spacing between accepted requests is 11 cycles.

## Configuration

- **`FIFO_REPL_INVALID_FIRST_EN` defined:**
  - During SCAN, the first way with its snapshot `valid` bit = 0 becomes the victim immediately, and SCAN exits to UPDATE on the next cycle.
  - Example: invalid way 2 → UPDATE at T+4, `ack` at T+5.
  - `dec` rule unchanged: applied relative to the chosen victim's counter.
- **Undefined:**
  - `valid_in` is still latched but ignored.
  - Pure FIFO selection with a fixed 8-cycle scan.

## Test plan

- **Reset:** assert `reset` for 2 cycles → all outputs 0, `busy`=0; `req` during reset → no `ack`.
- **Canonical FIFO:**
  - Stimulus: counters way0..7 = 7,6,5,4,3,2,1,0, all valid, `req` pulse.
  - Response: `ack` at T+10 with `victim`=7; UPDATE cycle has `load`=8'h80 and `dec`=8'h7F.
- **Tie / no zero:**
  - Stimulus: counters = 5,3,7,3,6,4,7,5.
  - Response: `victim`=1, `load`=8'h02, `dec`=8'hF5 (ways 0,2,4,5,6,7).
- **Snapshot isolation:**
  - Stimulus: change `ctr_in` to all 7 at T+3 of the canonical case.
  - Response: result identical to the canonical case; a second `req` held high is accepted immediately after DONE.
- **Reset mid-scan:** assert `reset` at T+5 → `busy` low the next cycle, and `load`/`dec`/`ack` never pulse.
- **Macro on:**
  - Stimulus: `valid_in`=8'hFB, canonical counters.
  - Response: `victim`=2, `ack` at T+5, `dec`=8'h03 (ways 0,1 > 5).
  - With the macro off, the same stimulus gives the canonical result.

Source files
------------

// File: rtl/fifo_repl_ctrl_if.sv
// fifo_repl_ctrl_if: miss-handler request/ack plus counter load/dec strobes for one 8-way FIFO set
interface fifo_repl_ctrl_if;
  logic        req;
  logic [23:0] ctr_in;
  logic [7:0]  valid_in;
  logic        busy;
  logic        ack;
  logic [2:0]  victim;
  logic [7:0]  load;
  logic [7:0]  dec;
  modport master (output req, ctr_in, valid_in, input busy, ack, victim, load, dec);
  modport slave  (input req, ctr_in, valid_in, output busy, ack, victim, load, dec);
endinterface

// File: rtl/fifo_repl_ctrl.sv
// fifo_repl_ctrl: FIFO victim selection and counter strobes for an 8-way set; FIFO_REPL_INVALID_FIRST_EN picks the first invalid way
module fifo_repl_ctrl (
  input logic clk,
  input logic reset,
  fifo_repl_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, UPDATE, DONE} state_e;
  state_e     state_q, state_d;
  logic [2:0] snap_q [8];
  logic [7:0] vsnap_q;
  logic [2:0] idx_q, best_q, best_d;
  logic [7:0] load_q, load_d, dec_q, dec_d;
  logic       pick_inv, last;
`ifdef FIFO_REPL_INVALID_FIRST_EN
  assign pick_inv = !vsnap_q[idx_q];
`else
  assign pick_inv = 1'b0 & vsnap_q[idx_q];
`endif
  assign best_d = (pick_inv || snap_q[idx_q] < snap_q[best_q]) ? idx_q : best_q;
  assign last   = pick_inv || idx_q == 3'd7;
  // strobes are registered on the SCAN exit edge so they span the whole UPDATE cycle
  always_comb begin
    load_d = '0;
    dec_d  = '0;
    if (state_q == SCAN && last) begin
      load_d[best_d] = 1'b1;
      for (int w = 0; w < 8; w++) dec_d[w] = snap_q[w] > snap_q[best_d];
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.req ? SCAN : IDLE;
      SCAN:    state_d = last ? UPDATE : SCAN;
      UPDATE:  state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      best_q  <= '0;
      vsnap_q <= '0;
      load_q  <= '0;
      dec_q   <= '0;
      for (int w = 0; w < 8; w++) snap_q[w] <= '0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      dec_q   <= dec_d;
      if (state_q == IDLE && bus.req) begin
        for (int w = 0; w < 8; w++) snap_q[w] <= bus.ctr_in[3*w +: 3];
        vsnap_q <= bus.valid_in;
        idx_q   <= '0;
        best_q  <= '0;
      end else if (state_q == SCAN) begin
        idx_q  <= idx_q + 3'd1;
        best_q <= best_d;
      end
    end
  end
  always_comb begin
    bus.busy   = state_q != IDLE;
    bus.ack    = state_q == DONE;
    bus.victim = best_q;
    bus.load   = load_q;
    bus.dec    = dec_q;
  end
endmodule

// File: tb/tb_fifo_repl_ctrl.sv
// tb_fifo_repl_ctrl: directed scenarios for fifo_repl_ctrl, sampled on the negedge
module tb_fifo_repl_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int fails = 0;
  localparam logic [23:0] CANON = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  localparam logic [23:0] TIE   = {3'd5, 3'd7, 3'd4, 3'd6, 3'd3, 3'd7, 3'd3, 3'd5};
  fifo_repl_ctrl_if bus ();
  fifo_repl_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic test_reset();
    bus.req = 1'b1; bus.ctr_in = CANON; bus.valid_in = 8'hFF; reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.ack, bus.victim, bus.load, bus.dec} !== 20'h0) begin
      fails++;
      $display("FAIL reset_outputs got %h want 0", {bus.busy, bus.ack, bus.victim, bus.load, bus.dec});
    end
    reset = 1'b0; bus.req = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.ack} !== 2'b00) begin
        fails++;
        $display("FAIL reset_no_ack cycle %0d busy/ack got %b want 00", k, {bus.busy, bus.ack});
      end
    end
  endtask

  task automatic test_canonical();
    logic [17:0] obs, exp;
    bus.ctr_in = CANON; bus.valid_in = 8'hFF; bus.req = 1'b1;
    @(negedge clk);
    bus.req = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      obs = {bus.busy, bus.ack, bus.load, bus.dec};
      exp = {k <= 10, k == 10, (k == 9) ? 8'h80 : 8'h00, (k == 9) ? 8'h7F : 8'h00};
      checks++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL canonical cycle %0d busy,ack,load,dec got %h want %h", k, obs, exp);
      end
      if (k >= 10) begin
        checks++;
        if (bus.victim !== 3'd7) begin
          fails++;
          $display("FAIL canonical_victim cycle %0d got %0d want 7", k, bus.victim);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_tie();
    logic [17:0] obs, exp;
    bus.ctr_in = TIE; bus.valid_in = 8'hFF; bus.req = 1'b1;
    @(negedge clk);
    bus.req = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      obs = {bus.busy, bus.ack, bus.load, bus.dec};
      exp = {k <= 10, k == 10, (k == 9) ? 8'h02 : 8'h00, (k == 9) ? 8'hF5 : 8'h00};
      checks++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL tie cycle %0d busy,ack,load,dec got %h want %h", k, obs, exp);
      end
      if (k >= 10) begin
        checks++;
        if (bus.victim !== 3'd1) begin
          fails++;
          $display("FAIL tie_victim cycle %0d got %0d want 1", k, bus.victim);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] obs, exp;
    bus.ctr_in = CANON; bus.valid_in = 8'hFF; bus.req = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 22; k++) begin
      if (k == 3) bus.ctr_in = 24'hFFFFFF;
      if (k == 12) bus.req = 1'b0;
      obs = {bus.busy, bus.ack, bus.load, bus.dec};
      exp = {k <= 10 || (k >= 12 && k <= 21), k == 10 || k == 21,
             (k == 9) ? 8'h80 : (k == 20) ? 8'h01 : 8'h00, (k == 9) ? 8'h7F : 8'h00};
      checks++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL snapshot cycle %0d busy,ack,load,dec got %h want %h", k, obs, exp);
      end
      if (k == 10 || k == 11 || k == 21) begin
        checks++;
        if (bus.victim !== ((k == 21) ? 3'd0 : 3'd7)) begin
          fails++;
          $display("FAIL snapshot_victim cycle %0d got %0d want %0d", k, bus.victim, (k == 21) ? 0 : 7);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [18:0] obs, exp;
    bus.ctr_in = CANON; bus.valid_in = 8'hFF; bus.req = 1'b1;
    @(negedge clk);
    bus.req = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      obs = {bus.busy, bus.ack, bus.load, bus.dec, k >= 6 ? (bus.victim == 3'd0) : 1'b1};
      exp = {k <= 5, 1'b0, 8'h00, 8'h00, 1'b1};
      checks++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL reset_mid_scan cycle %0d busy,ack,load,dec,victim0 got %h want %h", k, obs, exp);
      end
      if (k == 5) reset = 1'b1;
      if (k == 7) reset = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_invalid_first();
    logic [17:0] obs, exp;
    int uc;
    logic [2:0] ev;
    logic [7:0] el, ed;
`ifdef FIFO_REPL_INVALID_FIRST_EN
    uc = 4; ev = 3'd2; el = 8'h04; ed = 8'h03;
`else
    uc = 9; ev = 3'd7; el = 8'h80; ed = 8'h7F;
`endif
    bus.ctr_in = CANON; bus.valid_in = 8'hFB; bus.req = 1'b1;
    @(negedge clk);
    bus.req = 1'b0;
    for (int k = 1; k <= uc + 3; k++) begin
      obs = {bus.busy, bus.ack, bus.load, bus.dec};
      exp = {k <= uc + 1, k == uc + 1, (k == uc) ? el : 8'h00, (k == uc) ? ed : 8'h00};
      checks++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL invalid_first cycle %0d busy,ack,load,dec got %h want %h", k, obs, exp);
      end
      if (k > uc) begin
        checks++;
        if (bus.victim !== ev) begin
          fails++;
          $display("FAIL invalid_first_victim cycle %0d got %0d want %0d", k, bus.victim, ev);
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    bus.req = 1'b0; bus.ctr_in = '0; bus.valid_in = '0;
    @(negedge clk);
    test_reset();
    test_canonical();
    test_tie();
    test_back_to_back();
    test_reset_mid_scan();
    test_invalid_first();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
